// File: rtl/ctrl_fetch_decode_pkg.sv
// Shared types and instruction-field layout for the fetch/decode/control stage.
// The 16-bit instruction word is {opcode, rd, ra, rb}; the low byte doubles as imm/target.
package ctrl_fetch_decode_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int REG_AW  = 4;
  localparam int IMM_W   = 8;
  localparam int ALU_W   = 3;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_LDI  = 4'h5,
    OP_BZ   = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] wa;
    alu_op_t           alu_op;
    logic              alu_b_imm;
    logic [IMM_W-1:0]  imm;
    logic              is_write;
    logic              is_jmp;
    logic              is_bz;
    logic              is_halt;
  } decode_t;

  function automatic logic [REG_AW-1:0] reg_field(input logic [INSTR_W-1:0] word, input int lsb);
    return word[lsb +: REG_AW];
  endfunction

  function automatic logic [OPC_W-1:0] opc_field(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [IMM_W-1:0] imm_field(input logic [INSTR_W-1:0] word);
    return word[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/ctrl_fetch_decode_if.sv
// Instruction-memory and register-file/ALU control bundle between the controller
// (master) and the memory/datapath side (slave).
interface ctrl_fetch_decode_if #(
  parameter int unsigned PC_W = 8
);

  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [15:0]     imem_rdata;
  logic [3:0]      RA1;
  logic [3:0]      RA2;
  logic [3:0]      WA;
  logic            write_enable;
  logic [2:0]      alu_op;
  logic            alu_b_imm;
  logic [7:0]      imm;
  logic            rd1_is_zero;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_rdata,
    output RA1,
    output RA2,
    output WA,
    output write_enable,
    output alu_op,
    output alu_b_imm,
    output imm,
    input  rd1_is_zero
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_rdata,
    input  RA1,
    input  RA2,
    input  WA,
    input  write_enable,
    input  alu_op,
    input  alu_b_imm,
    input  imm,
    output rd1_is_zero
  );

endinterface

// File: rtl/ctrl_fetch_decode_instr_decode.sv
// Purely combinational instruction decoder: splits the IR into register addresses,
// ALU controls and the control-flow flags the sequencer needs in EXEC.
module instr_decode
  import ctrl_fetch_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output decode_t            dec_o
);

  logic [OPC_W-1:0] opc;

  always_comb begin
    opc             = opc_field(ir_i);
    dec_o           = '0;
    dec_o.ra1       = reg_field(ir_i, RA_LSB);
    dec_o.ra2       = reg_field(ir_i, RB_LSB);
    dec_o.wa        = reg_field(ir_i, RD_LSB);
    dec_o.imm       = imm_field(ir_i);
    dec_o.alu_op    = ALU_ADD;
    dec_o.alu_b_imm = 1'b0;

    case (opc)
      OP_ADD: begin
        dec_o.alu_op   = ALU_ADD;
        dec_o.is_write = 1'b1;
      end
      OP_SUB: begin
        dec_o.alu_op   = ALU_SUB;
        dec_o.is_write = 1'b1;
      end
      OP_AND: begin
        dec_o.alu_op   = ALU_AND;
        dec_o.is_write = 1'b1;
      end
      OP_OR: begin
        dec_o.alu_op   = ALU_OR;
        dec_o.is_write = 1'b1;
      end
      OP_XOR: begin
        dec_o.alu_op   = ALU_XOR;
        dec_o.is_write = 1'b1;
      end
      // LDI routes the immediate straight through the ALU's B side.
      OP_LDI: begin
        dec_o.alu_op    = ALU_PASSB;
        dec_o.alu_b_imm = 1'b1;
        dec_o.is_write  = 1'b1;
      end
      OP_BZ:   dec_o.is_bz   = 1'b1;
      OP_JMP:  dec_o.is_jmp  = 1'b1;
      OP_HALT: dec_o.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fetch_decode.sv
// Three-cycle FETCH/DECODE/EXEC sequencer owning PC and IR; drives instruction
// memory and the register-file/ALU controls, parks in HALT until reset.
module ctrl_fetch_decode
  import ctrl_fetch_decode_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  ctrl_fetch_decode_if.master        bus,
  output logic [PC_W-1:0]            pc,
  output logic                       halted
);

  ctrl_state_t          state_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      pc_d;
  logic [INSTR_W-1:0]   ir_q;
  logic                 halted_q;
  logic                 branch_taken;
  decode_t              dec;

  instr_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  // PC wraps naturally modulo 2^PC_W; HALT leaves it where it was.
  always_comb begin
    branch_taken = dec.is_jmp || (dec.is_bz && bus.rd1_is_zero);
    pc_d         = pc_q + PC_W'(1);
    if (branch_taken) begin
      pc_d = PC_W'(dec.imm);
    end else if (dec.is_halt) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (run) begin
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          ir_q    <= bus.imem_rdata;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          pc_q <= pc_d;
          if (dec.is_halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // Strobes are gated by reset so a reset landing mid-EXEC issues nothing that cycle.
  assign bus.imem_en      = (state_q == ST_FETCH) && run && !reset;
  assign bus.write_enable = (state_q == ST_EXEC) && dec.is_write && !reset;
  assign bus.imem_addr    = pc_q;
  assign bus.RA1          = dec.ra1;
  assign bus.RA2          = dec.ra2;
  assign bus.WA           = dec.wa;
  assign bus.alu_op       = dec.alu_op;
  assign bus.alu_b_imm    = dec.alu_b_imm;
  assign bus.imm          = dec.imm;

  assign pc     = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_fetch_decode.sv
// Self-checking bench: table of single-instruction vectors plus hand sequences,
// with a write scoreboard checked whenever the DUT strobes write_enable.
module tb_ctrl_fetch_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] pc;
  logic       halted;

  ctrl_fetch_decode_if #(.PC_W(8)) bus ();

  ctrl_fetch_decode #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [3:0] wa;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [2:0] op;
    logic       bimm;
    logic [7:0] imm;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_act;
  wr_t mon_exp;

  function automatic wr_t mk_wr(input logic [3:0] wa, input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [2:0] op, input logic bimm, input logic [7:0] imm);
    wr_t w;
    w.wa = wa; w.ra1 = ra1; w.ra2 = ra2; w.op = op; w.bimm = bimm; w.imm = imm;
    return w;
  endfunction

  // Scoreboard monitor: every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    #2;
    if (bus.write_enable === 1'b1) begin
      mon_act = mk_wr(bus.WA, bus.RA1, bus.RA2, bus.alu_op, bus.alu_b_imm, bus.imm);
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        $display("write WA=%0d RA1=%0d RA2=%0d alu_op=%0d b_imm=%0d imm=%02h",
                 bus.WA, bus.RA1, bus.RA2, bus.alu_op, bus.alu_b_imm, bus.imm);
        chk("write_fields", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  typedef struct {
    logic [15:0] instr;
    logic        rd1z;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        chk_op;
    logic [2:0]  op;
    logic        bimm;
    logic [7:0]  imm;
    logic [7:0]  pc_after;
    logic        halt;
  } vec_t;

  vec_t vecs [13];

  task automatic step(input logic rst_v, input logic run_v);
    @(negedge clk);
    reset = rst_v;
    run   = run_v;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 16'h6000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    bus.rd1_is_zero = 1'b0;
    fill_nop();

    //             instr    rd1z  we    wa     ra1    ra2    chkop op    bimm  imm     pc      halt
    vecs[0]  = '{16'h5107, 1'b0, 1'b1, 4'h1, 4'h0, 4'h7, 1'b1, 3'd5, 1'b1, 8'h07, 8'h01, 1'b0};
    vecs[1]  = '{16'h0312, 1'b1, 1'b1, 4'h3, 4'h1, 4'h2, 1'b1, 3'd0, 1'b0, 8'h12, 8'h01, 1'b0};
    vecs[2]  = '{16'h1A5C, 1'b0, 1'b1, 4'hA, 4'h5, 4'hC, 1'b1, 3'd1, 1'b0, 8'h5C, 8'h01, 1'b0};
    vecs[3]  = '{16'h2123, 1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 1'b1, 3'd2, 1'b0, 8'h23, 8'h01, 1'b0};
    vecs[4]  = '{16'h3456, 1'b0, 1'b1, 4'h4, 4'h5, 4'h6, 1'b1, 3'd3, 1'b0, 8'h56, 8'h01, 1'b0};
    vecs[5]  = '{16'h4789, 1'b0, 1'b1, 4'h7, 4'h8, 4'h9, 1'b1, 3'd4, 1'b0, 8'h89, 8'h01, 1'b0};
    vecs[6]  = '{16'h8010, 1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0, 1'b0, 8'h10, 8'h10, 1'b0};
    vecs[7]  = '{16'h8010, 1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0, 1'b0, 8'h10, 8'h01, 1'b0};
    vecs[8]  = '{16'h9042, 1'b0, 1'b0, 4'h0, 4'h4, 4'h2, 1'b0, 3'd0, 1'b0, 8'h42, 8'h42, 1'b0};
    vecs[9]  = '{16'h6123, 1'b1, 1'b0, 4'h1, 4'h2, 4'h3, 1'b0, 3'd0, 1'b0, 8'h23, 8'h01, 1'b0};
    vecs[10] = '{16'h7FFF, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h01, 1'b0};
    vecs[11] = '{16'hF000, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{16'h5000, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 3'd5, 1'b1, 8'h00, 8'h01, 1'b0};

    // Reset then idle with run low.
    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_imem_en", 32'(bus.imem_en), 32'h0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_we", 32'(bus.write_enable), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_decode", 32'({bus.RA1, bus.RA2, bus.WA, bus.alu_op, bus.alu_b_imm, bus.imm}), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0);
      chk("idle_pc", 32'(pc), 32'h0);
      chk("idle_imem_en", 32'(bus.imem_en), 32'h0);
      chk("idle_we", 32'(bus.write_enable), 32'h0);
    end
    step(1'b0, 1'b1);
    chk("idle_still_fetch", 32'(bus.imem_en), 32'h1);

    // Single-instruction vectors.
    for (int v = 0; v < 13; v++) begin
      fill_nop();
      mem[0] = vecs[v].instr;
      bus.rd1_is_zero = vecs[v].rd1z;
      do_reset();
      if (vecs[v].we)
        sb_q.push_back(mk_wr(vecs[v].wa, vecs[v].ra1, vecs[v].ra2, vecs[v].op, vecs[v].bimm, vecs[v].imm));
      $display("vector %0d: instr=%04h rd1_is_zero=%0d", v, vecs[v].instr, vecs[v].rd1z);
      step(1'b0, 1'b1);
      chk("vec_fetch_en", 32'(bus.imem_en), 32'h1);
      step(1'b0, 1'b0);
      chk("vec_decode_we", 32'(bus.write_enable), 32'h0);
      step(1'b0, 1'b0);
      chk("vec_exec_we", 32'(bus.write_enable), 32'(vecs[v].we));
      chk("vec_exec_regs", 32'({bus.WA, bus.RA1, bus.RA2}), 32'({vecs[v].wa, vecs[v].ra1, vecs[v].ra2}));
      chk("vec_exec_imm", 32'(bus.imm), 32'(vecs[v].imm));
      if (vecs[v].chk_op) begin
        chk("vec_exec_alu", 32'({bus.alu_op, bus.alu_b_imm}), 32'({vecs[v].op, vecs[v].bimm}));
      end
      step(1'b0, 1'b0);
      chk("vec_pc_after", 32'(pc), 32'(vecs[v].pc_after));
      chk("vec_halted", 32'(halted), 32'(vecs[v].halt));
      chk("vec_no_refetch", 32'(bus.imem_en), 32'h0);
    end

    // LDI r1,7; LDI r2,3; ADD r3,r1,r2 back to back.
    fill_nop();
    mem[0] = 16'h5107;
    mem[1] = 16'h5203;
    mem[2] = 16'h0312;
    mem[3] = 16'hF000;
    bus.rd1_is_zero = 1'b0;
    do_reset();
    sb_q.push_back(mk_wr(4'h1, 4'h0, 4'h7, 3'd5, 1'b1, 8'h07));
    sb_q.push_back(mk_wr(4'h2, 4'h0, 4'h3, 3'd5, 1'b1, 8'h03));
    sb_q.push_back(mk_wr(4'h3, 4'h1, 4'h2, 3'd0, 1'b0, 8'h12));
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      chk("seq_we_cycle", 32'(bus.write_enable), 32'((k % 3 == 0) && (k <= 9)));
      if (k == 9) chk("seq_add_ctrl", 32'({bus.RA1, bus.RA2, bus.alu_op, bus.alu_b_imm}), 32'({4'h1, 4'h2, 3'd0, 1'b0}));
      if (k == 10) chk("seq_pc_end", 32'(pc), 32'h3);
    end

    // JMP to 0xFF, then ADD r0 there wraps PC to 0.
    fill_nop();
    mem[0]     = 16'h90FF;
    mem[8'hFF] = 16'h0000;
    do_reset();
    sb_q.push_back(mk_wr(4'h0, 4'h0, 4'h0, 3'd0, 1'b0, 8'h00));
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1);
      if (k == 4) chk("jmp_pc_ff", 32'(bus.imem_addr), 32'hFF);
      if (k == 6) chk("wrap_we_wa0", 32'({bus.write_enable, bus.WA}), 32'({1'b1, 4'h0}));
      if (k == 7) chk("pc_wrap", 32'(pc), 32'h00);
    end

    // HALT parks the machine.
    fill_nop();
    mem[0] = 16'hF000;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1);
      chk("halt_flag", 32'(halted), 32'(k >= 4));
      if (k >= 4) begin
        chk("halt_no_fetch", 32'(bus.imem_en), 32'h0);
        chk("halt_pc", 32'(pc), 32'h0);
      end
    end

    // Reset arriving during EXEC of an ADD.
    fill_nop();
    mem[0] = 16'h0312;
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_exec_we", 32'(bus.write_enable), 32'h0);
    step(1'b1, 1'b0);
    chk("rst_exec_pc", 32'(pc), 32'h0);
    chk("rst_exec_we_after", 32'(bus.write_enable), 32'h0);
    step(1'b0, 1'b1);
    chk("rst_exec_refetch", 32'({bus.imem_en, bus.imem_addr}), 32'({1'b1, 8'h00}));

    // run dropped after FETCH: the instruction in flight still completes.
    fill_nop();
    mem[0] = 16'h5107;
    do_reset();
    sb_q.push_back(mk_wr(4'h1, 4'h0, 4'h7, 3'd5, 1'b1, 8'h07));
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("run_low_we", 32'(bus.write_enable), 32'h1);
    step(1'b0, 1'b0);
    chk("run_low_pc", 32'(pc), 32'h1);
    step(1'b0, 1'b0);
    chk("run_low_hold", 32'({bus.imem_en, pc}), 32'({1'b0, 8'h01}));

    do_reset();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
